hack_ram_loader: RTL and testbench

- Boot/program loader sitting directly upstream of the 8K-word Hack data RAM.
- Accepts a framed byte stream (e.g. from a UART receiver) over a valid/ready handshake and assembles big-endian 16-bit words.
- Drives the RAM's write port (data, load, address) with one write per assembled word.
- Verifies a trailing XOR checksum and reports done or error to the CPU/system controller.

---
 rtl/hack_pkg.sv | 38 +++
 rtl/hack_ram_loader_if.sv | 33 +++
 rtl/hack_byte_pair.sv | 40 ++++
 rtl/hack_ram_loader.sv | 181 ++++++++++++++++++
 tb/tb_hack_ram_loader.sv | 388 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hack_pkg.sv
// Shared definitions for the Hack RAM loader: RAM geometry, the loader
// state encoding and small header/checksum helpers.
package hack_pkg;

  localparam int HACK_DATA_W    = 16;
  localparam int HACK_ADDR_W    = 13;
  localparam int HACK_RAM_WORDS = 8192;
  localparam int HACK_CNT_W     = HACK_ADDR_W + 1;

  localparam logic [7:0] LOADER_SYNC = 8'hA5;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_SYNC = 4'd1,
    ST_AH   = 4'd2,
    ST_AL   = 4'd3,
    ST_CH   = 4'd4,
    ST_CL   = 4'd5,
    ST_DH   = 4'd6,
    ST_DL   = 4'd7,
    ST_WR   = 4'd8,
    ST_CK   = 4'd9,
    ST_DONE = 4'd10,
    ST_ERR  = 4'd11
  } loader_state_e;

  // A frame must carry between 1 and a full RAM worth of words.
  function automatic logic count_ok(input logic [15:0] c);
    return (c != 16'd0) && (c <= 16'(HACK_RAM_WORDS));
  endfunction

  // Bytes accepted in these states are folded into the frame checksum.
  function automatic logic in_checksum(input loader_state_e s);
    return (s == ST_AH) || (s == ST_AL) || (s == ST_CH) ||
           (s == ST_CL) || (s == ST_DH) || (s == ST_DL);
  endfunction

endpackage

// File: rtl/hack_ram_loader_if.sv
// Byte stream, RAM write port and status bundle of the RAM loader.
// Handshake: a byte moves when byte_valid && byte_ready are both 1 at a
// rising clk edge; byte_ready is registered and never looks at byte_valid,
// and the upstream must hold byte_in steady until the transfer happens.
interface hack_ram_loader_if;
  import hack_pkg::*;

  logic                   start;
  logic [7:0]             byte_in;
  logic                   byte_valid;
  logic                   byte_ready;
  logic [HACK_DATA_W-1:0] ram_in;
  logic                   ram_load;
  logic [HACK_ADDR_W-1:0] ram_address;
  logic                   busy;
  logic                   done;
  logic                   err;
  logic [HACK_CNT_W-1:0]  words_written;
  loader_state_e          state;

  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, ram_in, ram_load, ram_address,
    input  busy, done, err, words_written, state
  );

  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, ram_in, ram_load, ram_address,
    output busy, done, err, words_written, state
  );

endinterface

// File: rtl/hack_byte_pair.sv
// Big-endian word assembly and running XOR checksum for the loader.
// The high byte is latched; the word is presented as {hi, current byte}
// so the loader can register it on the same edge the low byte arrives.
module hack_byte_pair
  import hack_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear_i,
  input  logic                   acc_i,
  input  logic                   hi_en_i,
  input  logic [7:0]             byte_i,
  output logic [HACK_DATA_W-1:0] word_o,
  output logic [7:0]             csum_o
);

  logic [7:0] hi_q;
  logic [7:0] csum_q;

  // Latch the high data byte and accumulate / clear the checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= 8'd0;
      csum_q <= 8'd0;
    end else begin
      if (hi_en_i) begin
        hi_q <= byte_i;
      end
      if (clear_i) begin
        csum_q <= 8'd0;
      end else if (acc_i) begin
        csum_q <= csum_q ^ byte_i;
      end
    end
  end

  assign word_o = {hi_q, byte_i};
  assign csum_o = csum_q;

endmodule

// File: rtl/hack_ram_loader.sv
// Framed byte-stream loader for the 8K-word Hack data RAM.
// Frame: SYNC, addr hi/lo, count hi/lo, count x (data hi/lo), checksum.
// Each assembled word produces a single-cycle write in the WR state.
module hack_ram_loader
  import hack_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = LOADER_SYNC
) (
  input  logic              clk,
  input  logic              rst_n,
  hack_ram_loader_if.slave  bus
);

  loader_state_e          state_q;
  logic                   ready_q;
  logic                   ram_load_q;
  logic [HACK_DATA_W-1:0] ram_in_q;
  logic [HACK_ADDR_W-1:0] ram_addr_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   err_q;
  logic [HACK_CNT_W-1:0]  words_q;
  logic [HACK_ADDR_W-1:0] addr_q;
  logic [HACK_CNT_W-1:0]  remain_q;
  logic [7:0]             ah_q;
  logic [7:0]             ch_q;

  logic                   fire;
  logic                   arm;
  logic                   ah_bad;
  logic [HACK_ADDR_W-1:0] hdr_addr;
  logic [15:0]            hdr_count;
  logic [HACK_DATA_W-1:0] pair_word;
  logic [7:0]             pair_csum;

  assign fire      = bus.byte_valid && ready_q;
  assign arm       = bus.start &&
                     ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
  assign ah_bad    = (ah_q[7:5] != 3'd0);
  assign hdr_addr  = {ah_q[4:0], bus.byte_in};
  assign hdr_count = {ch_q, bus.byte_in};

  hack_byte_pair u_pair (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (arm),
    .acc_i   (fire && in_checksum(state_q)),
    .hi_en_i (fire && (state_q == ST_DH)),
    .byte_i  (bus.byte_in),
    .word_o  (pair_word),
    .csum_o  (pair_csum)
  );

  // Frame sequencer: header parsing, word writes, checksum verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b0;
      ram_load_q <= 1'b0;
      ram_in_q   <= '0;
      ram_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      words_q    <= '0;
      addr_q     <= '0;
      remain_q   <= '0;
      ah_q       <= 8'd0;
      ch_q       <= 8'd0;
    end else begin
      ram_load_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (bus.start) begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            words_q <= '0;
            busy_q  <= 1'b1;
            ready_q <= 1'b1;
            state_q <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          // Anything other than the marker is line noise and is dropped.
          if (fire && (bus.byte_in == SYNC_BYTE)) begin
            state_q <= ST_AH;
          end
        end
        ST_AH: begin
          if (fire) begin
            ah_q    <= bus.byte_in;
            state_q <= ST_AL;
          end
        end
        ST_AL: begin
          if (fire) begin
            addr_q <= hdr_addr;
            if (ah_bad) begin
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
              state_q <= ST_ERR;
            end else begin
              state_q <= ST_CH;
            end
          end
        end
        ST_CH: begin
          if (fire) begin
            ch_q    <= bus.byte_in;
            state_q <= ST_CL;
          end
        end
        ST_CL: begin
          if (fire) begin
            if (count_ok(hdr_count)) begin
              remain_q <= hdr_count[HACK_CNT_W-1:0];
              state_q  <= ST_DH;
            end else begin
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
              state_q <= ST_ERR;
            end
          end
        end
        ST_DH: begin
          if (fire) begin
            state_q <= ST_DL;
          end
        end
        ST_DL: begin
          // The full word exists only now, so the write pulse follows next cycle.
          if (fire) begin
            ready_q    <= 1'b0;
            ram_load_q <= 1'b1;
            ram_in_q   <= pair_word;
            ram_addr_q <= addr_q;
            state_q    <= ST_WR;
          end
        end
        ST_WR: begin
          words_q  <= words_q + 14'd1;
          addr_q   <= addr_q + 13'd1;
          remain_q <= remain_q - 14'd1;
          ready_q  <= 1'b1;
          state_q  <= (remain_q == 14'd1) ? ST_CK : ST_DH;
        end
        ST_CK: begin
          if (fire) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            if (bus.byte_in == pair_csum) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              err_q   <= 1'b1;
              state_q <= ST_ERR;
            end
          end
        end
        default: begin
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.byte_ready    = ready_q;
  assign bus.ram_load      = ram_load_q;
  assign bus.ram_in        = ram_in_q;
  assign bus.ram_address   = ram_addr_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.err           = err_q;
  assign bus.words_written = words_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_hack_ram_loader.sv
// Bench for hack_ram_loader: frames are built and scored against a
// frame-level reference model; a write monitor checks every RAM write.
module tb_hack_ram_loader;
  import hack_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  hack_ram_loader_if bus();

  hack_ram_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [28:0] exp_q[$];
  logic [7:0]  frame_q[$];
  logic [15:0] data_q[$];
  int          wr_cyc_q[$];
  int          acc_cyc_q[$];
  logic        exp_done;
  logic        exp_err;
  int          exp_words;

  // Every RAM write must match the next expected {address, data}.
  always @(negedge clk) begin
    if (rst_n && bus.ram_load) begin
      logic [28:0] e;
      checks++;
      wr_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write got addr=%h data=%h required no write", bus.ram_address, bus.ram_in);
      end else begin
        e = exp_q.pop_front();
        if ({bus.ram_address, bus.ram_in} !== e) begin
          failures++;
          $display("FAIL write got addr=%h data=%h required addr=%h data=%h",
                   bus.ram_address, bus.ram_in, e[28:16], e[15:0]);
        end
      end
      checks++;
      if (bus.byte_ready !== 1'b0) begin
        failures++;
        $display("FAIL ready_in_wr got %b required 0", bus.byte_ready);
      end
    end
    if (rst_n && (bus.done || bus.err)) begin
      checks++;
      if (bus.done && bus.err) begin
        failures++;
        $display("FAIL done_err_exclusive got done=1 err=1 required not both");
      end
    end
  end

  // ---------------- reference model ----------------
  // Builds a frame from data_q: header, data bytes, checksum XOR flip.
  task automatic make_frame(input logic [15:0] addr, input logic [15:0] cnt, input logic [7:0] flip);
    logic [7:0] cs;
    frame_q = {8'hA5, addr[15:8], addr[7:0], cnt[15:8], cnt[7:0]};
    cs = addr[15:8] ^ addr[7:0] ^ cnt[15:8] ^ cnt[7:0];
    foreach (data_q[k]) begin
      logic [15:0] w;
      w = data_q[k];
      frame_q.push_back(w[15:8]);
      frame_q.push_back(w[7:0]);
      cs = cs ^ w[15:8] ^ w[7:0];
    end
    frame_q.push_back(cs ^ flip);
  endtask

  // Interprets frame_q by the frame rules and queues the expected writes.
  task automatic model_frame();
    int i, ah, al, cnt, base;
    logic [7:0] cs;
    exp_done = 1'b0;
    exp_err = 1'b0;
    exp_words = 0;
    i = 0;
    while (i < frame_q.size() && frame_q[i] != 8'hA5) i++;
    i++;
    ah = int'(frame_q[i]);
    al = int'(frame_q[i+1]);
    cs = frame_q[i] ^ frame_q[i+1];
    i += 2;
    if (ah >= 32) begin exp_err = 1'b1; return; end
    base = ah * 256 + al;
    cnt = int'(frame_q[i]) * 256 + int'(frame_q[i+1]);
    cs = cs ^ frame_q[i] ^ frame_q[i+1];
    i += 2;
    if (cnt == 0 || cnt > 8192) begin exp_err = 1'b1; return; end
    for (int k = 0; k < cnt; k++) begin
      logic [12:0] a;
      a = 13'((base + k) % 8192);
      exp_q.push_back({a, frame_q[i], frame_q[i+1]});
      cs = cs ^ frame_q[i] ^ frame_q[i+1];
      exp_words++;
      i += 2;
    end
    if (frame_q[i] == cs) exp_done = 1'b1;
    else exp_err = 1'b1;
  endtask

  // ---------------- drivers ----------------
  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Sends frame_q; optional random valid drops and a stray start pulse.
  task automatic send_frame(input bit rand_valid, input int start_at);
    acc_cyc_q.delete();
    foreach (frame_q[i]) begin
      int n;
      bit acc;
      n = 0;
      acc = 1'b0;
      while (!acc && n < 200) begin
        bus.byte_in = frame_q[i];
        bus.byte_valid = rand_valid ? ($urandom_range(0, 2) != 0) : 1'b1;
        bus.start = (i == start_at) && (n == 0);
        if (bus.byte_valid && bus.byte_ready) begin
          acc = 1'b1;
          acc_cyc_q.push_back(cyc);
        end
        @(negedge clk);
        n++;
      end
      bus.byte_valid = 1'b0;
      bus.start = 1'b0;
      if (!acc) begin
        checks++;
        failures++;
        $display("FAIL byte_accept got no transfer for byte %0d required transfer", i);
        return;
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_drop got %b required 0", bus.busy);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.start = 1'b0;
    bus.byte_in = 8'hA5;
    bus.byte_valid = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.byte_ready, bus.ram_load, bus.ram_in, bus.ram_address, bus.busy,
         bus.done, bus.err, bus.words_written} !== 48'd0) begin
      failures++;
      $display("FAIL reset_outputs got nonzero outputs required all 0");
    end
    checks++;
    if (bus.state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_state got %0d required %0d", bus.state, ST_IDLE);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.state !== ST_IDLE || bus.byte_ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold got state=%0d ready=%b required state=0 ready=0", bus.state, bus.byte_ready);
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic test_basic();
    for (int g = 0; g < 2; g++) begin
      data_q = {16'h1234, 16'hABCD};
      make_frame(16'h0010, 16'd2, 8'h00);
      if (g == 1) frame_q = {8'h00, 8'hFF, 8'h5A, frame_q};
      model_frame();
      wr_cyc_q.delete();
      pulse_start();
      checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        failures++;
        $display("FAIL basic_armed got busy=%b done=%b required busy=1 done=0", bus.busy, bus.done);
      end
      send_frame(1'b0, -1);
      wait_idle();
      checks++;
      if (bus.done !== 1'b1 || bus.err !== 1'b0 || bus.words_written !== 14'd2) begin
        failures++;
        $display("FAIL basic_status g=%0d got done=%b err=%b words=%0d required done=1 err=0 words=2",
                 g, bus.done, bus.err, bus.words_written);
      end
      checks++;
      if (exp_q.size() != 0 || wr_cyc_q.size() != 2) begin
        failures++;
        $display("FAIL basic_writes got %0d writes required 2", wr_cyc_q.size());
        exp_q.delete();
      end else begin
        checks++;
        if (wr_cyc_q[0] != acc_cyc_q[6 + 3 * g] + 1 || wr_cyc_q[1] - wr_cyc_q[0] != 3) begin
          failures++;
          $display("FAIL write_timing got cyc=%0d gap=%0d required cyc=%0d gap=3",
                   wr_cyc_q[0], wr_cyc_q[1] - wr_cyc_q[0], acc_cyc_q[6 + 3 * g] + 1);
        end
      end
    end
  endtask

  task automatic test_wrap();
    data_q = {16'h1111, 16'h2222};
    make_frame(16'h1FFF, 16'd2, 8'h00);
    model_frame();
    pulse_start();
    send_frame(1'b0, -1);
    wait_idle();
    checks++;
    if (bus.done !== 1'b1 || bus.words_written !== 14'd2 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL wrap got done=%b words=%0d missing=%0d required done=1 words=2 missing=0",
               bus.done, bus.words_written, exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (bus.ram_address !== 13'h0000) begin
      failures++;
      $display("FAIL wrap_last_addr got %h required 0000", bus.ram_address);
    end
  endtask

  task automatic test_bad_header();
    for (int c = 0; c < 2; c++) begin
      if (c == 0) frame_q = {8'hA5, 8'h00, 8'h10, 8'h00, 8'h00};
      else        frame_q = {8'hA5, 8'h20, 8'h00};
      model_frame();
      wr_cyc_q.delete();
      pulse_start();
      send_frame(1'b0, -1);
      wait_idle();
      checks++;
      if (bus.err !== 1'b1 || bus.done !== 1'b0 || bus.state !== ST_ERR) begin
        failures++;
        $display("FAIL bad_header c=%0d got err=%b done=%b state=%0d required err=1 done=0 state=%0d",
                 c, bus.err, bus.done, bus.state, ST_ERR);
      end
      checks++;
      if (wr_cyc_q.size() != 0 || bus.words_written !== 14'd0) begin
        failures++;
        $display("FAIL bad_header_writes c=%0d got %0d writes required 0", c, wr_cyc_q.size());
      end
    end
  endtask

  task automatic test_bad_checksum();
    data_q = {16'($urandom), 16'($urandom), 16'($urandom)};
    make_frame(16'h0100, 16'd3, 8'h01);
    model_frame();
    pulse_start();
    send_frame(1'b0, -1);
    wait_idle();
    checks++;
    if (bus.err !== 1'b1 || bus.done !== 1'b0 || bus.words_written !== 14'd3 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL bad_checksum got err=%b done=%b words=%0d missing=%0d required err=1 done=0 words=3 missing=0",
               bus.err, bus.done, bus.words_written, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_flow_random();
    for (int f = 0; f < 8; f++) begin
      int cnt;
      logic [7:0] flip;
      cnt = $urandom_range(1, 5);
      data_q.delete();
      for (int k = 0; k < cnt; k++) data_q.push_back(16'($urandom));
      flip = ($urandom_range(0, 2) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
      make_frame(16'($urandom_range(0, 8191)), 16'(cnt), flip);
      if (f % 3 == 1) frame_q = {8'(($urandom_range(0, 1) == 0) ? 8'h3C : 8'hA4), frame_q};
      model_frame();
      pulse_start();
      send_frame(1'b1, $urandom_range(1, 4));
      wait_idle();
      checks++;
      if (bus.done !== exp_done || bus.err !== exp_err || bus.words_written !== 14'(exp_words)) begin
        failures++;
        $display("FAIL flow f=%0d got done=%b err=%b words=%0d required done=%b err=%b words=%0d",
                 f, bus.done, bus.err, bus.words_written, exp_done, exp_err, exp_words);
      end
      checks++;
      if (exp_q.size() != 0) begin
        failures++;
        $display("FAIL flow_writes f=%0d got %0d missing writes required 0", f, exp_q.size());
        exp_q.delete();
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    data_q = {16'h5555, 16'h6666};
    make_frame(16'h0005, 16'd2, 8'h00);
    frame_q = frame_q[0:5];
    pulse_start();
    send_frame(1'b0, -1);
    checks++;
    if (bus.state !== ST_DL) begin
      failures++;
      $display("FAIL mid_frame_state got %0d required %0d", bus.state, ST_DL);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.byte_ready, bus.ram_load, bus.ram_in, bus.ram_address, bus.busy,
         bus.done, bus.err, bus.words_written} !== 48'd0 || bus.state !== ST_IDLE) begin
      failures++;
      $display("FAIL async_reset got state=%0d load=%b busy=%b required all 0 and IDLE",
               bus.state, bus.ram_load, bus.busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wr_cyc_q.delete();
    repeat (3) @(negedge clk);
    checks++;
    if (wr_cyc_q.size() != 0 || bus.state !== ST_IDLE) begin
      failures++;
      $display("FAIL post_reset got writes=%0d state=%0d required writes=0 state=0", wr_cyc_q.size(), bus.state);
    end
    data_q = {16'h1234, 16'hABCD};
    make_frame(16'h0010, 16'd2, 8'h00);
    model_frame();
    pulse_start();
    send_frame(1'b0, -1);
    wait_idle();
    checks++;
    if (bus.done !== 1'b1 || bus.words_written !== 14'd2 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL reload got done=%b words=%0d missing=%0d required done=1 words=2 missing=0",
               bus.done, bus.words_written, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.start = 1'b0;
    bus.byte_in = 8'h00;
    bus.byte_valid = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_wrap();
    test_bad_header();
    test_bad_checksum();
    test_flow_random();
    test_reset_mid_frame();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
